// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer and its program memory.
package seq_pkg;

  localparam int IW     = 12;
  localparam int OP_MSB = 11;
  localparam int OP_LSB = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x IW register array, synchronous write, combinational read.
module seq_prog_mem
  import seq_pkg::*;
#(
  parameter int WIDTH = IW,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Issues the first prog_len program words in order over a valid/ready interface.
// Optional SEQ_LOOP_EN adds a loop input that restarts the program without a bubble.
module instruction_sequencer
  import seq_pkg::*;
#(
  parameter int IW    = seq_pkg::IW,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stop,
`ifdef SEQ_LOOP_EN
  input  logic          loop,
`endif
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [AW-1:0] last_pc;
  logic          loop_q;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;
  logic          hs;
  logic          at_last;
  logic          mem_we;

  assign hs      = instr_valid && instr_ready;
  assign at_last = (pc == last_pc);
  assign mem_we  = prog_we && (state != RUN);

  // Read the word that will be presented next cycle, so issue never bubbles.
  always_comb begin
    rd_addr = pc + AW'(1);
    if (state != RUN || at_last) rd_addr = '0;
  end

  seq_prog_mem #(
    .WIDTH(IW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      loop_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !stop) begin
            if (prog_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= RUN;
              pc          <= '0;
              instr_out   <= rd_data;
              instr_valid <= 1'b1;
              busy        <= 1'b1;
              last_pc     <= AW'(prog_len - 1'b1);
`ifdef SEQ_LOOP_EN
              loop_q      <= loop;
`else
              loop_q      <= 1'b0;
`endif
            end
          end
        end
        RUN: begin
          done <= 1'b0;
          if (stop) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
          end else if (hs) begin
            if (at_last && !loop_q) begin
              state       <= DONE;
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              // rd_addr already folds the wrap back to 0 for looping runs.
              pc        <= rd_addr;
              instr_out <= rd_data;
              done      <= at_last;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Issues stored 12-bit instructions to the datapath executor, one per handshake, in program order. A small loadable program memory is written by the host or testbench. After a start pulse, a program counter steps through the first `prog_len` words and presents each on a valid/ready interface. This block replaces hand-sequenced instruction stimulus. It sits directly upstream of the instruction input of the `source` datapath.

## Interface
- `IW`, 12, instruction width: opcode in bits [11:9], operand fields in [8:0]
- `DEPTH`, 16, program memory words; power of two
- `AW`, $clog2(DEPTH), address and PC width
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `prog_we`  in  1  program-memory write strobe
- `prog_addr`  in  AW  write address
- `prog_data`  in  IW  write data
- `prog_len`  in  AW+1  number of words to issue, 0..DEPTH; sampled on accepted `start`
- `start`  in  1  one-cycle request to begin issuing from address 0
- `stop`  in  1  abort request
- `instr_out`  out  IW  instruction presented to the executor
- `instr_valid`  out  1  `instr_out` is valid
- `instr_ready`  in  1  executor accepts `instr_out` this cycle
- `pc`  out  AW  address of the word currently presented
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse when the last word is accepted, or when a zero-length run ends

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: presents words to the executor.
  - DONE: lasts one cycle, `done`=1.
- IDLE→RUN:
  - Occurs on `start` with `prog_len` != 0.
  - Latches the length and sets `pc`=0.
- IDLE→DONE: occurs on `start` with `prog_len`=0. No word is issued.
- RUN:
  - `instr_valid`=1 and `instr_out`=mem[`pc`].
  - On `instr_valid && instr_ready`: if `pc` = len−1, go to DONE; otherwise increment `pc`.
- DONE→IDLE: unconditional on the next cycle.
- `stop` in RUN:
  - Next state is IDLE and `instr_valid` drops.
  - A handshake completing in the same cycle as `stop` still counts as accepted.
  - `done` is not pulsed.
- `start` in RUN or DONE: ignored.
- `prog_we` in IDLE or DONE: writes mem[`prog_addr`] <= `prog_data`.
- `prog_we` in RUN: ignored, so the running program is immutable.
- `stop` and `start` in the same IDLE cycle: `stop` wins and the block stays in IDLE.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values: state IDLE, `pc`=0, `instr_out`=0, `instr_valid`=0, `busy`=0, `done`=0.
- `rst` mid-run: the next cycle is IDLE with all outputs at their reset values. No `done` pulse.
- `instr_out`, `instr_valid`, `pc` and `busy` are registered. The first word is valid the cycle after `start`.
- Throughput with `instr_ready` held at 1: one word per cycle. N words take N cycles from the first valid.
- `done` is high the cycle after the last handshake. `instr_valid` is 0 in that cycle.
- Stall rule: while `instr_valid && !instr_ready`, `instr_out` and `pc` hold stable.
- `instr_valid` never drops without a handshake, except on `stop` or `rst`.
- `pc` wraps only through the `prog_len`=DEPTH case: the last word is at DEPTH−1, and the next state is DONE (or 0 under looping).

## Configuration
- Macro: `SEQ_LOOP_EN`.
- Defined:
  - Adds input `loop` (1 bit), sampled on accepted `start`.
  - With `loop`=1, acceptance of word len−1 sets `pc`=0 and the block stays in RUN, with no bubble cycle.
  - `done` pulses on every wrap.
  - The run ends only on `stop` or `rst`.
- Undefined: no `loop` port; behaviour is exactly as in Operation.

## Structure
- Shared package `seq_pkg` holds:
  - `IW` default
  - opcode field constants `OP_MSB`=11, `OP_LSB`=9
  - state typedef {IDLE, RUN, DONE}
- Sub-module `seq_prog_mem`:
  - DEPTH×IW register array
  - synchronous write port, combinational read port
- `instr_out` is registered from its read data. The next-PC address is used so that no bubble is inserted between words.

## Test plan
- Back-to-back issue:
  - Load 0x03C, 0x04F, 0x20A, 0x40B, 0x60C, 0x80D, 0xA0E, 0xC10, 0xE0F at addresses 0–8; `prog_len`=9; `start`; `instr_ready`=1.
  - Expect the nine words on nine consecutive cycles with `pc` 0..8, then `done` for one cycle, then IDLE.
- Backpressure:
  - Same program; `instr_ready` alternates 0/1 starting at 0.
  - Each word holds for 2 cycles, 18 valid cycles in total, and the order is unchanged.
- Zero length: `prog_len`=0 with `start` → `done` the next cycle, `instr_valid` never asserted.
- Abort:
  - `stop` while `pc`=3 and `instr_ready`=0 → IDLE next cycle, `instr_valid`=0, no `done`.
  - Then `prog_we` to address 3 succeeds.
- Reset and ignored inputs:
  - `rst` while `pc`=5 → all outputs at reset values next cycle.
  - `start` and `prog_we` during RUN have no effect on the issued sequence.
- Looping (`SEQ_LOOP_EN`): `prog_len`=3 with `loop`=1 → sequence 0,1,2,0,1,2 with `done` after each address 2, until `stop`.
